// File: rtl/seq_mul16.sv
// Unsigned 16x16 shift-and-add multiplier with valid/ready handshakes.
// A single 16-bit ripple-carry adder performs every partial-product addition.

module _16bit_rca (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] s,
   output logic        c_out
);

   logic [16:0] w_carry;

   assign w_carry[0] = c_in;

   for (genvar i = 0; i < 16; i++) begin : g_fa
      assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i + 1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
   end

   assign c_out = w_carry[16];

endmodule

module seq_mul16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] p
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [15:0] r_mcand;
   logic [15:0] r_acc;
   logic [15:0] r_mplr;
   logic [4:0]  r_cnt;

   logic [15:0] w_addend;
   logic [15:0] w_sum;
   logic        w_cout;
   logic        w_accept;
   logic        w_lastIter;

   assign w_addend   = r_mplr[0] ? r_mcand : 16'h0000;
   assign w_accept   = (r_state == IDLE) && in_valid;
   assign w_lastIter = (r_cnt == 5'd15);

   _16bit_rca u_rca (
      .a     (r_acc),
      .b     (w_addend),
      .c_in  (1'b0),
      .s     (w_sum),
      .c_out (w_cout)
   );

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)   w_nextState = BUSY;
         BUSY:    if (w_lastIter) w_nextState = DONE;
         DONE:    if (out_ready)  w_nextState = IDLE;
         default:                 w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The adder carry-out becomes acc[15] as the 33-bit sum shifts right by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand <= 16'h0000;
         r_acc   <= 16'h0000;
         r_mplr  <= 16'h0000;
         r_cnt   <= 5'd0;
      end else if (w_accept) begin
         r_mcand <= a;
         r_acc   <= 16'h0000;
         r_mplr  <= b;
         r_cnt   <= 5'd0;
      end else if (r_state == BUSY) begin
         r_acc   <= {w_cout, w_sum[15:1]};
         r_mplr  <= {w_sum[0], r_mplr[15:1]};
         r_cnt   <= r_cnt + 5'd1;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign p         = {r_acc, r_mplr};

endmodule
